verifica_senha: RTL
===================

// Module: verifica_senha
// PURPOSE
//  Downstream consumer of the keypad PIN assembler: takes each completed pinPac_t, compares it
//  against the master PIN and the four user PINs held in setupPac_t, and reports success/failure.
//  Counts consecutive failures and enforces a timed lockout, exporting remaining seconds for the
//  7-seg path. master_ok feeds the setup / master-update flow; pin_ok drives the lock actuator.
// PARAMETERS
//  CLK_FREQ_HZ  10  clk cycles per second (divided system clock); sets the 1 s tick
//  MAX_TRIES    3   consecutive failures that trigger lockout
//  LOCK_S       10  lockout duration in seconds (<=99)
// PORTS
//  clk             in   1    system clock (divided)
//  rst             in   1    asynchronous, active-high reset
//  enable          in   1    1 = accept PIN entries; 0 = ignore entries (lockout timer keeps running)
//  pin_in          in   17   pinPac_t from the assembler; status high >=1 cycle when PIN complete
//  data_setup      in   ~85  setupPac_t; master_pin and pin1..pin4 used, slot valid when status=1
//  pin_ok          out  1    1-cycle pulse: entry matched master or any valid user slot
//  pin_fail        out  1    1-cycle pulse: entry matched nothing
//  master_ok       out  1    1-cycle pulse, coincident with pin_ok, when entry equals master_pin
//  locked          out  1    level: lockout active
//  lock_remaining  out  7    seconds left in lockout, 0 when not locked
//  fail_count      out  3    consecutive failures, saturates at 7
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, prescaler 0, stored status_d 0.
//  - Entry event = rising edge of pin_in.status (status high now, status_d low), sampled only in
//    IDLE with enable=1. Held status (2 cycles from assembler) yields exactly one event.
//  - FSM IDLE -> COMPARE on event: digits latched into internal register in that same edge.
//    COMPARE -> RESULT: match flags registered (master, pin1..pin4; slot valid only if its status=1
//    and no digit equals 4'hE). RESULT: pulse outputs for one cycle, then IDLE or LOCKED.
//  - Latency: event sampled at edge N -> pin_ok/pin_fail/master_ok high during cycle after edge N+2.
//  - Success: fail_count <= 0. Failure: fail_count <= sat(fail_count+1); if new count >= MAX_TRIES
//    -> LOCKED with lock_remaining <= LOCK_S, prescaler cleared, locked=1 same edge as pin_fail.
//  - Each failure after a completed lockout (count still >= MAX_TRIES) re-enters LOCKED immediately.
//  - LOCKED: every CLK_FREQ_HZ cycles decrement lock_remaining; at 1->0 transition go IDLE, locked=0
//    same edge. Entries during LOCKED are ignored: no pulse, fail_count unchanged.
//  - enable=0 while in COMPARE/RESULT: current comparison aborted, no pulse, return to IDLE.
//  - Master pin with status=0 never matches; all slots invalid -> every entry fails.
//  - pin_in digits changing after the event are irrelevant (latched copy used).
//  - rst mid-lockout: lockout and fail_count cleared instantly.
// STRUCTURE
//  - Shared package senha_pkg: pinPac_t, setupPac_t, DIGIT_BLANK=4'hE, pin_eq() compare function.
//  - Sub-module gera_tick (enable/clear, CLK_FREQ_HZ param, 1-cycle tick out) for the 1 s strobe.
//  - FSM states enumerated locally: IDLE, COMPARE, RESULT, LOCKED.
// TESTING (CLK_FREQ_HZ=10, MAX_TRIES=3, LOCK_S=10)
//  1. master=1234(st=1), entry 1234 status held 2 cyc -> single pin_ok+master_ok, 2 cycles after edge.
//  2. pin2=5678(st=1), entry 5678 -> pin_ok=1, master_ok=0; pin3=5678 with st=0 alone -> pin_fail.
//  3. Three entries 0000 -> fail_count 1,2,3; locked=1 on 3rd pin_fail edge, lock_remaining=10.
//  4. During lockout enter 1234 -> no pulses; after 100 cycles lock_remaining=0, locked=0; 1234 -> pin_ok, fail_count=0.
//  5. Slot pin1 digits E,E,E,E st=1 and entry EEEE -> pin_fail (blank never matches).
//  6. rst pulse at lock_remaining=6 -> locked=0, fail_count=0, all outputs 0; enable=0 entry -> ignored.

Source files
------------

// File: rtl/senha_pkg.sv
// Shared types for the PIN path: assembler packet, setup packet and the slot compare helper.
package senha_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'hE;

  typedef struct packed {
    logic [3:0][3:0] digits;
    logic            status;
  } pinPac_t;

  typedef struct packed {
    pinPac_t master_pin;
    pinPac_t pin1;
    pinPac_t pin2;
    pinPac_t pin3;
    pinPac_t pin4;
  } setupPac_t;

  // A slot matches only when it is valid, holds no blank digit and equals the entry.
  function automatic logic pin_eq(input logic [3:0][3:0] entry, input pinPac_t slot);
    logic blank;
    blank = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (slot.digits[i] == DIGIT_BLANK) blank = 1'b1;
    end
    return slot.status && !blank && (entry == slot.digits);
  endfunction

endpackage

// File: rtl/gera_tick.sv
// Prescaler producing a one-cycle strobe every CLK_FREQ_HZ enabled cycles.
module gera_tick #(
  parameter int CLK_FREQ_HZ = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_FREQ_HZ - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (r_cnt == LAST);

endmodule

// File: rtl/verifica_senha.sv
// PIN checker: compares each completed entry with master/user slots, counts failures, times lockout.
module verifica_senha
  import senha_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_S      = 10
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enable,
  input  pinPac_t   pin_in,
  input  setupPac_t data_setup,
  output logic      pin_ok,
  output logic      pin_fail,
  output logic      master_ok,
  output logic      locked,
  output logic [6:0] lock_remaining,
  output logic [2:0] fail_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE, COMPARE, RESULT, LOCKED} state_t;

  state_t          r_state;
  logic            r_status_d;
  logic [3:0][3:0] r_digits;
  logic            r_m_master;
  logic [3:0]      r_m_user;
  logic            r_pin_ok;
  logic            r_pin_fail;
  logic            r_master_ok;
  logic            r_locked;
  logic [6:0]      r_lock_rem;
  logic [2:0]      r_fail;

  logic       w_tick;
  logic       w_event;
  logic [2:0] w_fail_next;

  gera_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (r_state == LOCKED),
    .clr  (r_state != LOCKED),
    .tick (w_tick)
  );

  assign w_event     = pin_in.status && !r_status_d;
  assign w_fail_next = (r_fail == 3'd7) ? 3'd7 : r_fail + 3'd1;

  // Valid/ready contract: pin_in is "valid" on the rising edge of its status bit; the block is
  // "ready" only in IDLE with enable=1, and events seen at any other time are simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_status_d  <= 1'b0;
      r_digits    <= '0;
      r_m_master  <= 1'b0;
      r_m_user    <= '0;
      r_pin_ok    <= 1'b0;
      r_pin_fail  <= 1'b0;
      r_master_ok <= 1'b0;
      r_locked    <= 1'b0;
      r_lock_rem  <= '0;
      r_fail      <= '0;
    end else begin
      r_status_d  <= pin_in.status;
      r_pin_ok    <= 1'b0;
      r_pin_fail  <= 1'b0;
      r_master_ok <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && w_event) begin
            r_digits <= pin_in.digits;
            r_state  <= COMPARE;
          end
        end
        COMPARE: begin
          if (!enable) begin
            r_state <= IDLE;
          end else begin
            r_m_master <= pin_eq(r_digits, data_setup.master_pin);
            r_m_user   <= {pin_eq(r_digits, data_setup.pin4), pin_eq(r_digits, data_setup.pin3),
                           pin_eq(r_digits, data_setup.pin2), pin_eq(r_digits, data_setup.pin1)};
            r_state    <= RESULT;
          end
        end
        RESULT: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (r_m_master || (|r_m_user)) begin
            r_pin_ok    <= 1'b1;
            r_master_ok <= r_m_master;
            r_fail      <= '0;
            r_state     <= IDLE;
          end else begin
            r_pin_fail <= 1'b1;
            r_fail     <= w_fail_next;
            // A count already at/above the limit relocks on every further failure.
            if (int'(w_fail_next) >= MAX_TRIES) begin
              r_locked   <= 1'b1;
              r_lock_rem <= 7'(LOCK_S);
              r_state    <= LOCKED;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        LOCKED: begin
          if (w_tick) begin
            if (r_lock_rem <= 7'd1) begin
              r_lock_rem <= '0;
              r_locked   <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_lock_rem <= r_lock_rem - 7'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pin_ok         = r_pin_ok;
  assign pin_fail       = r_pin_fail;
  assign master_ok      = r_master_ok;
  assign locked         = r_locked;
  assign lock_remaining = r_lock_rem;
  assign fail_count     = r_fail;
  assign dbg_state      = r_state;

endmodule
